id_ex_stage_register: RTL and testbench

- Pipeline register between the decode-stage stall-insertion mux (bubble mux) and the execute stage of the 5-stage MIPS datapath.
- Captures the gated control bundle and the decode data operands each cycle. Supports hold (stall), flush (bubble injection) and a valid flag.
- Keeps a saturating count of bubbles entering EX for debug/perf readout.

---
 rtl/id_ex_stage_register_pkg.sv | 27 ++
 rtl/pipe_field_reg.sv | 35 +++
 rtl/id_ex_stage_register.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_register_pkg.sv
// Shared widths and the ID/EX control bundle used by the bubble mux and the ID/EX register.
package id_ex_stage_register_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned ALUCTL_W = 5;
   localparam int unsigned MEMCTL_W = 2;

   typedef struct packed {
      logic                reg_write;
      logic                alu_src;
      logic                reg_dst;
      logic [MEMCTL_W-1:0] mem_write;
      logic [MEMCTL_W-1:0] mem_read;
      logic                branch;
      logic                mem_to_reg;
      logic                jump;
      logic                jr;
      logic                jal;
      logic [ALUCTL_W-1:0] alu_control;
      logic                shift_control;
   } ctrl_t;

   // All-zero control: what the bubble mux selects on a hazard stall.
   localparam ctrl_t CtrlZero = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field: hold on ~en_i, synchronous clear on clr_i, async active-high reset.
module pipe_field_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_d, data_q;

   // Clear wins over hold so a flush lands even while EX is stalled.
   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (en_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with stall, flush, slot-valid FSM and a saturating bubble counter.
module id_ex_stage_register #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned ALUCTL_W = 5,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Stall,
   input  logic                Flush,
   input  logic                BubbleIn,
   input  logic                RegWriteIn,
   input  logic                ALUSrcIn,
   input  logic                RegDstIn,
   input  logic                BranchIn,
   input  logic                MemToRegIn,
   input  logic                JumpIn,
   input  logic                JrIn,
   input  logic                JalIn,
   input  logic                ShiftControlIn,
   input  logic [1:0]          MemWriteIn,
   input  logic [1:0]          MemReadIn,
   input  logic [ALUCTL_W-1:0] ALUControlIn,
   input  logic [DATA_W-1:0]   PCPlus4In,
   input  logic [DATA_W-1:0]   ReadData1In,
   input  logic [DATA_W-1:0]   ReadData2In,
   input  logic [DATA_W-1:0]   SignExtImmIn,
   input  logic [REG_W-1:0]    RsIn,
   input  logic [REG_W-1:0]    RtIn,
   input  logic [REG_W-1:0]    RdIn,
   input  logic [REG_W-1:0]    ShamtIn,
   output logic                RegWriteOut,
   output logic                ALUSrcOut,
   output logic                RegDstOut,
   output logic                BranchOut,
   output logic                MemToRegOut,
   output logic                JumpOut,
   output logic                JrOut,
   output logic                JalOut,
   output logic                ShiftControlOut,
   output logic [1:0]          MemWriteOut,
   output logic [1:0]          MemReadOut,
   output logic [ALUCTL_W-1:0] ALUControlOut,
   output logic [DATA_W-1:0]   PCPlus4Out,
   output logic [DATA_W-1:0]   ReadData1Out,
   output logic [DATA_W-1:0]   ReadData2Out,
   output logic [DATA_W-1:0]   SignExtImmOut,
   output logic [REG_W-1:0]    RsOut,
   output logic [REG_W-1:0]    RtOut,
   output logic [REG_W-1:0]    RdOut,
   output logic [REG_W-1:0]    ShamtOut,
   output logic                ValidOut,
   output logic [CNT_W-1:0]    BubbleCount
);

   import id_ex_stage_register_pkg::ctrl_t;

   typedef enum logic {StEmpty, StFull} slot_e;

   ctrl_t            ctrl_in, ctrl_q;
   slot_e            state_d, state_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic             load_en;
   logic             bubble_evt;

   assign load_en = ~Stall;

   assign ctrl_in = '{
      reg_write:     RegWriteIn,
      alu_src:       ALUSrcIn,
      reg_dst:       RegDstIn,
      mem_write:     MemWriteIn,
      mem_read:      MemReadIn,
      branch:        BranchIn,
      mem_to_reg:    MemToRegIn,
      jump:          JumpIn,
      jr:            JrIn,
      jal:           JalIn,
      alu_control:   ALUControlIn,
      shift_control: ShiftControlIn
   };

   pipe_field_reg #(.WIDTH($bits(ctrl_t))) u_ctrl (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(ctrl_in), .q_o(ctrl_q));
   pipe_field_reg #(.WIDTH(DATA_W)) u_pc_plus4 (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(PCPlus4In), .q_o(PCPlus4Out));
   pipe_field_reg #(.WIDTH(DATA_W)) u_read_data1 (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(ReadData1In),
      .q_o(ReadData1Out));
   pipe_field_reg #(.WIDTH(DATA_W)) u_read_data2 (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(ReadData2In),
      .q_o(ReadData2Out));
   pipe_field_reg #(.WIDTH(DATA_W)) u_sign_ext_imm (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(SignExtImmIn),
      .q_o(SignExtImmOut));
   pipe_field_reg #(.WIDTH(REG_W)) u_rs (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(RsIn), .q_o(RsOut));
   pipe_field_reg #(.WIDTH(REG_W)) u_rt (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(RtIn), .q_o(RtOut));
   pipe_field_reg #(.WIDTH(REG_W)) u_rd (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(RdIn), .q_o(RdOut));
   pipe_field_reg #(.WIDTH(REG_W)) u_shamt (
      .clk_i(Clk), .rst_i(Reset), .en_i(load_en), .clr_i(Flush), .d_i(ShamtIn), .q_o(ShamtOut));

   assign RegWriteOut     = ctrl_q.reg_write;
   assign ALUSrcOut       = ctrl_q.alu_src;
   assign RegDstOut       = ctrl_q.reg_dst;
   assign MemWriteOut     = ctrl_q.mem_write;
   assign MemReadOut      = ctrl_q.mem_read;
   assign BranchOut       = ctrl_q.branch;
   assign MemToRegOut     = ctrl_q.mem_to_reg;
   assign JumpOut         = ctrl_q.jump;
   assign JrOut           = ctrl_q.jr;
   assign JalOut          = ctrl_q.jal;
   assign ALUControlOut   = ctrl_q.alu_control;
   assign ShiftControlOut = ctrl_q.shift_control;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (Flush) begin
         state_d = StEmpty;
      end else if (!Stall) begin
         state_d = BubbleIn ? StEmpty : StFull;
      end
   end

   always_comb begin
      ValidOut = (state_q == StFull);
   end

   // A flush coinciding with BubbleIn is one bubble, not two.
   assign bubble_evt = Flush | (~Stall & BubbleIn);

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_evt && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign BubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for the ID/EX register; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage_register;

   logic Clk = 1'b0;
   logic Reset, Stall, Flush, BubbleIn;
   logic RegWriteIn, ALUSrcIn, RegDstIn, BranchIn, MemToRegIn, JumpIn, JrIn, JalIn;
   logic ShiftControlIn;
   logic [1:0] MemWriteIn, MemReadIn;
   logic [4:0] ALUControlIn;
   logic [31:0] PCPlus4In, ReadData1In, ReadData2In, SignExtImmIn;
   logic [4:0] RsIn, RtIn, RdIn, ShamtIn;

   logic RegWriteOut, ALUSrcOut, RegDstOut, BranchOut, MemToRegOut, JumpOut, JrOut, JalOut;
   logic ShiftControlOut, ValidOut;
   logic [1:0] MemWriteOut, MemReadOut;
   logic [4:0] ALUControlOut;
   logic [31:0] PCPlus4Out, ReadData1Out, ReadData2Out, SignExtImmOut;
   logic [4:0] RsOut, RtOut, RdOut, ShamtOut;
   logic [15:0] BubbleCount;

   logic s_reg_write, s_alu_src, s_reg_dst, s_branch, s_mem_to_reg, s_jump, s_jr, s_jal;
   logic s_shift, s_valid;
   logic [1:0] s_mem_write, s_mem_read;
   logic [4:0] s_alu_ctl;
   logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
   logic [4:0] s_rs, s_rt, s_rd, s_shamt;
   logic [3:0] s_cnt;

   int total = 0;
   int bad = 0;

   always #5 Clk = ~Clk;

   id_ex_stage_register u_dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .BubbleIn(BubbleIn),
      .RegWriteIn(RegWriteIn), .ALUSrcIn(ALUSrcIn), .RegDstIn(RegDstIn), .BranchIn(BranchIn),
      .MemToRegIn(MemToRegIn), .JumpIn(JumpIn), .JrIn(JrIn), .JalIn(JalIn),
      .ShiftControlIn(ShiftControlIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
      .ALUControlIn(ALUControlIn), .PCPlus4In(PCPlus4In), .ReadData1In(ReadData1In),
      .ReadData2In(ReadData2In), .SignExtImmIn(SignExtImmIn), .RsIn(RsIn), .RtIn(RtIn),
      .RdIn(RdIn), .ShamtIn(ShamtIn),
      .RegWriteOut(RegWriteOut), .ALUSrcOut(ALUSrcOut), .RegDstOut(RegDstOut),
      .BranchOut(BranchOut), .MemToRegOut(MemToRegOut), .JumpOut(JumpOut), .JrOut(JrOut),
      .JalOut(JalOut), .ShiftControlOut(ShiftControlOut), .MemWriteOut(MemWriteOut),
      .MemReadOut(MemReadOut), .ALUControlOut(ALUControlOut), .PCPlus4Out(PCPlus4Out),
      .ReadData1Out(ReadData1Out), .ReadData2Out(ReadData2Out), .SignExtImmOut(SignExtImmOut),
      .RsOut(RsOut), .RtOut(RtOut), .RdOut(RdOut), .ShamtOut(ShamtOut),
      .ValidOut(ValidOut), .BubbleCount(BubbleCount));

   id_ex_stage_register #(.CNT_W(4)) u_sat (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .BubbleIn(BubbleIn),
      .RegWriteIn(RegWriteIn), .ALUSrcIn(ALUSrcIn), .RegDstIn(RegDstIn), .BranchIn(BranchIn),
      .MemToRegIn(MemToRegIn), .JumpIn(JumpIn), .JrIn(JrIn), .JalIn(JalIn),
      .ShiftControlIn(ShiftControlIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
      .ALUControlIn(ALUControlIn), .PCPlus4In(PCPlus4In), .ReadData1In(ReadData1In),
      .ReadData2In(ReadData2In), .SignExtImmIn(SignExtImmIn), .RsIn(RsIn), .RtIn(RtIn),
      .RdIn(RdIn), .ShamtIn(ShamtIn),
      .RegWriteOut(s_reg_write), .ALUSrcOut(s_alu_src), .RegDstOut(s_reg_dst),
      .BranchOut(s_branch), .MemToRegOut(s_mem_to_reg), .JumpOut(s_jump), .JrOut(s_jr),
      .JalOut(s_jal), .ShiftControlOut(s_shift), .MemWriteOut(s_mem_write),
      .MemReadOut(s_mem_read), .ALUControlOut(s_alu_ctl), .PCPlus4Out(s_pc4),
      .ReadData1Out(s_rd1), .ReadData2Out(s_rd2), .SignExtImmOut(s_imm),
      .RsOut(s_rs), .RtOut(s_rt), .RdOut(s_rd), .ShamtOut(s_shamt),
      .ValidOut(s_valid), .BubbleCount(s_cnt));

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic zero_inputs();
      {RegWriteIn, ALUSrcIn, RegDstIn, BranchIn, MemToRegIn, JumpIn, JrIn, JalIn} = '0;
      ShiftControlIn = 1'b0;
      MemWriteIn = 2'b00;
      MemReadIn = 2'b00;
      ALUControlIn = 5'h00;
      {PCPlus4In, ReadData1In, ReadData2In, SignExtImmIn} = '0;
      {RsIn, RtIn, RdIn, ShamtIn} = '0;
   endtask

   initial begin
      Reset = 1'b1;
      Stall = 1'b0;
      Flush = 1'b0;
      BubbleIn = 1'b0;
      zero_inputs();
      step();
      step();
      check_val("rst_valid", ValidOut, 0);
      check_val("rst_cnt", BubbleCount, 0);
      check_val("rst_pc4", PCPlus4Out, 0);
      Reset = 1'b0;

      // Normal load
      RegWriteIn = 1'b1;
      MemReadIn = 2'b11;
      RtIn = 5'd9;
      ALUControlIn = 5'h0A;
      ReadData1In = 32'hDEADBEEF;
      SignExtImmIn = 32'hFFFF_FFF4;
      step();
      check_val("load_regwrite", RegWriteOut, 1);
      check_val("load_memread", MemReadOut, 2'b11);
      check_val("load_rt", RtOut, 9);
      check_val("load_aluctl", ALUControlOut, 5'h0A);
      check_val("load_rd1", ReadData1Out, 32'hDEADBEEF);
      check_val("load_imm", SignExtImmOut, 32'hFFFF_FFF4);
      check_val("load_valid", ValidOut, 1);
      check_val("load_cnt", BubbleCount, 0);

      // Stall hold; BubbleIn must be ignored while stalled
      Stall = 1'b1;
      RtIn = 5'd3;
      RegWriteIn = 1'b0;
      BubbleIn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val($sformatf("stall_rt%0d", i), RtOut, 9);
         check_val($sformatf("stall_regwrite%0d", i), RegWriteOut, 1);
         check_val($sformatf("stall_valid%0d", i), ValidOut, 1);
         check_val($sformatf("stall_cnt%0d", i), BubbleCount, 0);
      end
      BubbleIn = 1'b0;

      // Flush beats stall
      RegWriteIn = 1'b1;
      Flush = 1'b1;
      step();
      check_val("flush_regwrite", RegWriteOut, 0);
      check_val("flush_memread", MemReadOut, 0);
      check_val("flush_aluctl", ALUControlOut, 0);
      check_val("flush_rd1", ReadData1Out, 0);
      check_val("flush_rt", RtOut, 0);
      check_val("flush_valid", ValidOut, 0);
      check_val("flush_cnt", BubbleCount, 1);
      Flush = 1'b0;
      Stall = 1'b0;

      // Hazard bubble: zeroed control, data still copied
      zero_inputs();
      BubbleIn = 1'b1;
      PCPlus4In = 32'h40;
      step();
      check_val("bub_valid", ValidOut, 0);
      check_val("bub_pc4", PCPlus4Out, 32'h40);
      check_val("bub_cnt", BubbleCount, 2);

      // Flush together with BubbleIn counts once
      Flush = 1'b1;
      step();
      check_val("flushbub_cnt", BubbleCount, 3);
      check_val("flushbub_sat_cnt", s_cnt, 3);
      check_val("flushbub_pc4", PCPlus4Out, 0);
      Flush = 1'b0;
      BubbleIn = 1'b0;

      // EMPTY -> FULL on a real instruction
      JalIn = 1'b1;
      MemWriteIn = 2'b10;
      ReadData1In = 32'hDEADBEEF;
      ALUControlIn = 5'h0A;
      step();
      check_val("refill_valid", ValidOut, 1);
      check_val("refill_jal", JalOut, 1);
      check_val("refill_memwrite", MemWriteOut, 2'b10);
      check_val("refill_cnt", BubbleCount, 3);

      // Asynchronous reset between edges
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      check_val("arst_rd1", ReadData1Out, 0);
      check_val("arst_aluctl", ALUControlOut, 0);
      check_val("arst_jal", JalOut, 0);
      check_val("arst_valid", ValidOut, 0);
      check_val("arst_cnt", BubbleCount, 0);
      check_val("arst_sat_cnt", s_cnt, 0);
      Flush = 1'b1;
      step();
      check_val("arst_hold_rd1", ReadData1Out, 0);
      check_val("arst_hold_cnt", BubbleCount, 0);
      Flush = 1'b0;
      Reset = 1'b0;

      // Saturation of the 4-bit counter over 20 bubbles
      zero_inputs();
      BubbleIn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check_val($sformatf("sat_small%0d", i), s_cnt, (i + 1 > 15) ? 15 : i + 1);
         check_val($sformatf("sat_wide%0d", i), BubbleCount, i + 1);
      end
      BubbleIn = 1'b0;
      Flush = 1'b1;
      step();
      check_val("sat_flush_small", s_cnt, 4'hF);
      check_val("sat_flush_wide", BubbleCount, 21);
      Flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
